sseg_scan_mux: RTL



---
 rtl/sseg_pkg.sv | 37 +++
 rtl/sseg_hex_decode.sv | 13 +
 rtl/sseg_scan_mux.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyphs (bit0 = a .. bit6 = g)
// and the parameter-legality helpers used at elaboration time.
package sseg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_TABLE [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };

    function automatic logic num_digits_ok(input int n);
        return (n >= 1) && (n <= 8);
    endfunction

    function automatic logic prescale_ok(input int p);
        return p >= 2;
    endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern lookup.
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/sseg_scan_mux.sv
// N-digit multiplexed seven-segment driver: prescaled scan, frame-aligned double buffer, PWM dimming.
// Optional build macro SSEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 100000,
    parameter int DUTY_W     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    input  logic [DUTY_W-1:0]       brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              sseg,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    if (!num_digits_ok(NUM_DIGITS)) begin : g_bad_num_digits
        $error("sseg_scan_mux: NUM_DIGITS must be in 1..8");
    end
    if (!prescale_ok(PRESCALE)) begin : g_bad_prescale
        $error("sseg_scan_mux: PRESCALE must be >= 2");
    end

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [DUTY_W-1:0]       pwm_cnt;
    logic [4*NUM_DIGITS-1:0] stage_value, disp_value;
    logic [NUM_DIGITS-1:0]   stage_dp, disp_dp;
    logic [NUM_DIGITS-1:0]   stage_blank, disp_blank;
    logic                    pending;

    logic                    tick;
    logic                    frame_boundary;
    logic                    dead;
    logic                    slot_on;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    cur_blank;
    logic [3:0]              cur_nibble;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   an_d;

    assign tick           = (presc == PRESC_LAST);
    assign frame_boundary = tick && (idx == IDX_LAST);
    assign frame_done     = frame_boundary;
    // Slot count 0 is the dead cycle that separates one digit's anode from the next.
    assign dead           = (presc == '0);
    assign slot_on        = (&brightness) || (pwm_cnt < brightness);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc   <= '0;
            idx     <= '0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (tick) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // load is a strobe with an always-ready receiver: every cycle it is high is a capture,
    // so the last load before a frame boundary is the one that reaches the display.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_value <= '0;
            stage_dp    <= '0;
            stage_blank <= '0;
            disp_value  <= '0;
            disp_dp     <= '0;
            disp_blank  <= '0;
            pending     <= 1'b0;
        end else if (load && frame_boundary) begin
            stage_value <= value;
            stage_dp    <= dp;
            stage_blank <= blank;
            disp_value  <= value;
            disp_dp     <= dp;
            disp_blank  <= blank;
            pending     <= 1'b0;
        end else begin
            if (frame_boundary && pending) begin
                disp_value <= stage_value;
                disp_dp    <= stage_dp;
                disp_blank <= stage_blank;
                pending    <= 1'b0;
            end
            if (load) begin
                stage_value <= value;
                stage_dp    <= dp;
                stage_blank <= blank;
                pending     <= 1'b1;
            end
        end
    end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and everything above it is an undotted 0.
    always_comb begin
        logic zero_run;
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run && (disp_value[4*i +: 4] == 4'h0) && !disp_dp[i];
            lz_blank[i] = zero_run;
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign cur_nibble = disp_value[{idx, 2'b00} +: 4];
    assign cur_blank  = disp_blank[idx] | lz_blank[idx];

    sseg_hex_decode u_hex_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        an_d = '1;
        if (!dead && slot_on && !cur_blank) begin
            an_d[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an   <= '1;
            sseg <= SEG_OFF;
            dp_n <= 1'b1;
        end else begin
            an   <= an_d;
            sseg <= dec_seg;
            dp_n <= ~disp_dp[idx];
        end
    end

endmodule
